// File: rtl/sram_bytewr_init_pkg.sv
// Shared definitions for the byte-writable SRAM with its hardware clear sequencer.
// Default geometry matches the CPU top so both can refer to the same values.
package sram_bytewr_init_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefDepth     = 2048;
  localparam int unsigned DefAdxWidth  = 11;

  typedef enum logic {
    StClear = 1'b0,
    StRun   = 1'b1
  } sram_state_e;

endpackage

// File: rtl/sram_bytewr_init_if.sv
// Request/response bus between the MEM stage (master) and the SRAM (slave).
interface sram_bytewr_init_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADX_WIDTH  = 11
) ();

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                  req;
  logic                  we;
  logic [BE_WIDTH-1:0]   be;
  logic [ADX_WIDTH-1:0]  adx;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;

  modport master (
    output req, we, be, adx, wdata,
    input  ready, rdata, rvalid
  );

  modport slave (
    input  req, we, be, adx, wdata,
    output ready, rdata, rvalid
  );

endinterface

// File: rtl/sram_bytewr_init_array.sv
// Pure storage: unreset word array with byte-lane writes and a registered read port.
module sram_bytewr_init_array #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned ADX_WIDTH  = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_we,
  input  logic [DATA_WIDTH/8-1:0]    mem_be,
  input  logic [ADX_WIDTH-1:0]       mem_adx,
  input  logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic                       rd_en,
  input  logic                       rd_zero,
  output logic [DATA_WIDTH-1:0]      rd_data
);

  localparam int unsigned BeWidth = DATA_WIDTH / 8;
  localparam int unsigned IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IdxW-1:0]       idx;
  logic                  unused_adx;

  // Out-of-range accesses are filtered upstream, so the truncated index is safe.
  assign idx        = mem_adx[IdxW-1:0];
  assign unused_adx = ^mem_adx;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BeWidth; i++) begin
        if (mem_be[i]) begin
          mem[idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_zero ? '0 : mem[idx];
    end
  end

endmodule

// File: rtl/sram_bytewr_init.sv
// Single-port SRAM front end: clear-on-reset sequencer, request decode and range check.
module sram_bytewr_init
  import sram_bytewr_init_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = DefDataWidth,
  parameter int unsigned          DEPTH      = DefDepth,
  parameter int unsigned          ADX_WIDTH  = DefAdxWidth,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic                 clk,
  input logic                 rst,
  sram_bytewr_init_if.slave   bus
);

  localparam int unsigned          BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADX_WIDTH-1:0] LastAdx  = ADX_WIDTH'(DEPTH - 1);
  localparam logic [ADX_WIDTH:0]   DepthW   = (ADX_WIDTH + 1)'(DEPTH);

  sram_state_e            state_q, state_d;
  logic [ADX_WIDTH-1:0]   clr_adx_q, clr_adx_d;
  logic                   ready_q, ready_d;
  logic                   rvalid_q, rvalid_d;

  logic                   in_range;
  logic                   mem_we;
  logic [BE_WIDTH-1:0]    mem_be;
  logic [ADX_WIDTH-1:0]   mem_adx;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic                   rd_en;

  assign in_range = {1'b0, bus.adx} < DepthW;

  always_comb begin
    state_d   = state_q;
    clr_adx_d = clr_adx_q;
    ready_d   = ready_q;
    rvalid_d  = 1'b0;
    mem_we    = 1'b0;
    mem_be    = bus.be;
    mem_adx   = bus.adx;
    mem_wdata = bus.wdata;
    rd_en     = 1'b0;
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_be    = '1;
        mem_adx   = clr_adx_q;
        mem_wdata = INIT_VALUE;
        // Stop on the compare, not on wrap, so DEPTH == 2**ADX_WIDTH works.
        if (clr_adx_q == LastAdx) begin
          state_d = StRun;
          ready_d = 1'b1;
        end else begin
          clr_adx_d = clr_adx_q + ADX_WIDTH'(1);
        end
      end
      StRun: begin
        if (bus.req) begin
          if (bus.we) begin
            mem_we = in_range;
          end else begin
            rd_en    = 1'b1;
            rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = StClear;
    endcase
    // Reset wins over any pending write, including a clear write.
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      clr_adx_q <= '0;
      ready_q   <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_adx_q <= clr_adx_d;
      ready_q   <= ready_d;
      rvalid_q  <= rvalid_d;
    end
  end

  sram_bytewr_init_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADX_WIDTH  (ADX_WIDTH)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_adx   (mem_adx),
    .mem_wdata (mem_wdata),
    .rd_en     (rd_en),
    .rd_zero   (~in_range),
    .rd_data   (bus.rdata)
  );

  assign bus.ready  = ready_q;
  assign bus.rvalid = rvalid_q;

endmodule

// File: tb/tb_sram_bytewr_init.sv
// Directed plus random bench for sram_bytewr_init against an array-based memory model.
module tb_sram_bytewr_init;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 5;
  localparam logic [15:0] INIT  = 16'hA5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sram_bytewr_init_if #(.DATA_WIDTH(DW), .ADX_WIDTH(AW)) bus ();

  sram_bytewr_init #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADX_WIDTH  (AW),
    .INIT_VALUE (INIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned total  = 0;
  int unsigned passed = 0;

  // Reference model: memory contents, words still to clear, and expected outputs.
  logic [15:0] ref_mem [DEPTH];
  int          clr_pos  = 0;
  logic        m_ready  = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [15:0] m_rdata  = 16'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, advance the model by one edge, then compare all outputs.
  task automatic step(input logic r, input logic q, input logic w, input logic [1:0] b,
                      input logic [4:0] a, input logic [15:0] d);
    rst       = r;
    bus.req   = q;
    bus.we    = w;
    bus.be    = b;
    bus.adx   = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    if (r) begin
      clr_pos  = 0;
      m_ready  = 1'b0;
      m_rvalid = 1'b0;
      m_rdata  = 16'h0;
    end else if (!m_ready) begin
      ref_mem[clr_pos] = INIT;
      clr_pos++;
      m_ready  = (clr_pos == DEPTH);
      m_rvalid = 1'b0;
    end else if (q && w) begin
      if (a < DEPTH) begin
        if (b[0]) ref_mem[a][7:0]  = d[7:0];
        if (b[1]) ref_mem[a][15:8] = d[15:8];
      end
      m_rvalid = 1'b0;
    end else if (q) begin
      m_rdata  = (a < DEPTH) ? ref_mem[a] : 16'h0;
      m_rvalid = 1'b1;
    end else begin
      m_rvalid = 1'b0;
    end
    check("ready", {31'b0, bus.ready}, {31'b0, m_ready});
    check("rvalid", {31'b0, bus.rvalid}, {31'b0, m_rvalid});
    check("rdata", {16'b0, bus.rdata}, {16'b0, m_rdata});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d, input logic [1:0] b);
    step(1'b0, 1'b1, 1'b1, b, a, d);
  endtask

  task automatic rd(input logic [4:0] a);
    step(1'b0, 1'b1, 1'b0, 2'b00, a, 16'h0);
  endtask

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.be = '0; bus.adx = '0; bus.wdata = '0;

    // 1: reset, clear takes exactly DEPTH edges, then every word reads INIT.
    step(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
    for (int k = 1; k <= DEPTH; k++) begin
      idle();
      check("ready_timing", {31'b0, bus.ready}, {31'b0, (k == DEPTH)});
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd(5'(i));
      check("init_word", {16'b0, bus.rdata}, {16'b0, INIT});
    end
    idle();

    // 2: full-word write then read back.
    wr(5'd3, 16'h1234, 2'b11);
    rd(5'd3);
    check("rd_1234", {16'b0, bus.rdata}, 32'h1234);
    check("rv_1234", {31'b0, bus.rvalid}, 32'h1);

    // 3: low-lane write, then an all-lanes-disabled write.
    wr(5'd3, 16'hFFFF, 2'b01);
    rd(5'd3);
    check("rd_12ff", {16'b0, bus.rdata}, 32'h12FF);
    wr(5'd3, 16'h0000, 2'b00);
    rd(5'd3);
    check("rd_be0", {16'b0, bus.rdata}, 32'h12FF);

    // 4: out-of-range write dropped, out-of-range read returns 0 with rvalid.
    wr(5'd20, 16'hBEEF, 2'b11);
    rd(5'd20);
    check("oor_rdata", {16'b0, bus.rdata}, 32'h0);
    check("oor_rvalid", {31'b0, bus.rvalid}, 32'h1);
    rd(5'd4);
    check("adx4_intact", {16'b0, bus.rdata}, {16'b0, INIT});

    // 5: reset mid-clear restarts from zero; reset on an accepted read kills rvalid.
    step(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
    for (int k = 0; k < 7; k++) idle();
    step(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 16'h0);
    for (int k = 1; k <= DEPTH; k++) begin
      idle();
      check("restart_ready", {31'b0, bus.ready}, {31'b0, (k == DEPTH)});
    end
    rd(5'd3);
    step(1'b1, 1'b1, 1'b0, 2'b00, 5'd3, 16'h0);
    check("rst_kills_rvalid", {31'b0, bus.rvalid}, 32'h0);

    // 6: write attempt during clear is ignored.
    for (int k = 0; k < DEPTH; k++) wr(5'd2, 16'h0000, 2'b11);
    rd(5'd2);
    check("clear_ignores_req", {16'b0, bus.rdata}, {16'b0, INIT});

    // Random traffic, including in-flight resets and out-of-range addresses.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), 2'($urandom),
           5'($urandom_range(0, 23)), 16'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
